// File: rtl/fifo_ram_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_ram_ctrl_if
//  Purpose  : Producer, consumer and RAM-port bundle for fifo_ram_ctrl.
//  Revision : 1.0  initial release
// ============================================================================
interface fifo_ram_ctrl_if #(
    parameter int C_WIDTH = 32,
    parameter int C_DEPTH = 1024
);
    localparam int c_aw = (C_DEPTH > 1) ? $clog2(C_DEPTH) : 1;

    logic               WR_VALID;
    logic [C_WIDTH-1:0] WR_DATA;
    logic               WR_READY;
    logic               RD_VALID;
    logic [C_WIDTH-1:0] RD_DATA;
    logic               RD_READY;
    logic [c_aw+1:0]    COUNT;
    logic               RAM_WR_EN;
    logic [c_aw-1:0]    RAM_WR_ADDR;
    logic [C_WIDTH-1:0] RAM_WR_DATA;
    logic               RAM_RD_EN;
    logic [c_aw-1:0]    RAM_RD_ADDR;
    logic [C_WIDTH-1:0] RAM_RD_DATA;

    // Controller side
    modport slave (
        input  WR_VALID, WR_DATA, RD_READY, RAM_RD_DATA,
        output WR_READY, RD_VALID, RD_DATA, COUNT,
               RAM_WR_EN, RAM_WR_ADDR, RAM_WR_DATA, RAM_RD_EN, RAM_RD_ADDR
    );

    // Producer / consumer / RAM side
    modport master (
        output WR_VALID, WR_DATA, RD_READY, RAM_RD_DATA,
        input  WR_READY, RD_VALID, RD_DATA, COUNT,
               RAM_WR_EN, RAM_WR_ADDR, RAM_WR_DATA, RAM_RD_EN, RAM_RD_ADDR
    );
endinterface
`default_nettype wire

// File: rtl/fifo_ram_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_ram_ctrl
//  Purpose  : FWFT FIFO controller around an external 1-cycle-latency SDP RAM.
//  Revision : 1.0  initial release
// ============================================================================
module fifo_ram_ctrl #(
    parameter int C_WIDTH = 32,
    parameter int C_DEPTH = 1024
) (
    input  wire logic         CLK,
    input  wire logic         RST_N,
    fifo_ram_ctrl_if.slave    bus
);
    localparam int c_aw = (C_DEPTH > 1) ? $clog2(C_DEPTH) : 1;
    localparam int c_cw = c_aw + 1;
    localparam int c_tw = c_aw + 2;
    localparam logic [c_cw-1:0] c_depth = c_cw'(C_DEPTH);

    logic [c_aw-1:0]    r_wptr;
    logic [c_aw-1:0]    r_rptr;
    logic [c_cw-1:0]    r_ram_cnt;
    logic               r_inflight;
    logic [1:0]         r_occ;
    logic [C_WIDTH-1:0] r_head;
    logic [C_WIDTH-1:0] r_skid;
    logic               r_wr_ready;
    logic [c_tw-1:0]    r_count;

    logic               w_wr_en;
    logic               w_pop;
    logic               w_rd_en;
    logic               w_push_head;
    logic [c_cw-1:0]    w_ram_cnt_nxt;
    logic [1:0]         w_occ_nxt;
    logic [c_tw-1:0]    w_count_nxt;

    always_comb begin
        w_wr_en       = bus.WR_VALID & r_wr_ready;
        w_pop         = (r_occ != 2'd0) & bus.RD_READY;
        // Issue only if the landing word will have a free output-stage slot
        w_rd_en       = (r_ram_cnt != '0) &
                        ((3'(r_occ) + 3'(r_inflight)) < (3'd2 + 3'(w_pop)));
        w_push_head   = (r_occ == 2'd0) | ((r_occ == 2'd1) & w_pop);
        w_ram_cnt_nxt = r_ram_cnt + c_cw'(w_wr_en) - c_cw'(w_rd_en);
        w_occ_nxt     = r_occ - 2'(w_pop) + 2'(r_inflight);
        w_count_nxt   = c_tw'(w_ram_cnt_nxt) + c_tw'(w_rd_en) + c_tw'(w_occ_nxt);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_ram_cnt  <= '0;
            r_inflight <= 1'b0;
            r_occ      <= 2'd0;
            r_head     <= '0;
            r_skid     <= '0;
            r_wr_ready <= 1'b0;
            r_count    <= '0;
        end else begin
            r_wr_ready <= (w_ram_cnt_nxt < c_depth);
            r_ram_cnt  <= w_ram_cnt_nxt;
            r_inflight <= w_rd_en;
            r_occ      <= w_occ_nxt;
            r_count    <= w_count_nxt;
            if (w_wr_en) begin
                r_wptr <= r_wptr + c_aw'(1);
            end
            if (w_rd_en) begin
                r_rptr <= r_rptr + c_aw'(1);
            end
            if (w_pop && (r_occ == 2'd2)) begin
                r_head <= r_skid;
            end
            // A full output stage never has a read in flight, so no collision
            if (r_inflight) begin
                if (w_push_head) begin
                    r_head <= bus.RAM_RD_DATA;
                end else begin
                    r_skid <= bus.RAM_RD_DATA;
                end
            end
        end
    end

    assign bus.WR_READY    = r_wr_ready;
    assign bus.RD_VALID    = (r_occ != 2'd0);
    assign bus.RD_DATA     = r_head;
    assign bus.COUNT       = r_count;
    assign bus.RAM_WR_EN   = w_wr_en;
    assign bus.RAM_WR_ADDR = r_wptr;
    assign bus.RAM_WR_DATA = bus.WR_DATA;
    assign bus.RAM_RD_EN   = w_rd_en;
    assign bus.RAM_RD_ADDR = r_rptr;

endmodule
`default_nettype wire

// File: doc/fifo_ram_ctrl.md
# fifo_ram_ctrl

Sequencing controller that turns one external `scsdpram` instance into a synchronous first-word-fall-through FIFO with valid/ready handshakes on both sides. It owns the RAM write and read ports, tracks occupancy, and hides the RAM's one-cycle read latency behind a two-entry output stage. It is used wherever an action kernel needs deep buffering between a producer and a consumer in the same clock domain. Capacity is C_DEPTH + 2 words, and it sustains one word per cycle in each direction.

## Interface
- C_WIDTH, 32, data width in bits; must match the attached RAM.
- C_DEPTH, 1024, RAM depth in words; a power of 2 and at least 2.
- CLK  in  1  rising-edge clock, shared with the RAM.
- RST_N  in  1  asynchronous, active-low reset.
- WR_VALID  in  1  producer has a word.
- WR_DATA  in  C_WIDTH  producer word.
- WR_READY  out  1  controller accepts a word; a transfer occurs when WR_VALID & WR_READY.
- RD_VALID  out  1  RD_DATA holds the FIFO head.
- RD_DATA  out  C_WIDTH  FIFO head word.
- RD_READY  in  1  consumer takes the head; a transfer occurs when RD_VALID & RD_READY.
- COUNT  out  clog2s(C_DEPTH)+2  total words held (RAM + in-flight + output stage).
- RAM_WR_EN  out  1  to RAM WR1_EN.
- RAM_WR_ADDR  out  clog2s(C_DEPTH)  to RAM WR1_ADDR.
- RAM_WR_DATA  out  C_WIDTH  to RAM WR1_DATA.
- RAM_RD_EN  out  1  to RAM RD1_EN.
- RAM_RD_ADDR  out  clog2s(C_DEPTH)  to RAM RD1_ADDR.
- RAM_RD_DATA  in  C_WIDTH  from RAM RD1_DATA; valid one cycle after RAM_RD_EN.

## Operation
- **State.**
  - wptr and rptr: clog2s(C_DEPTH) bits each; they wrap modulo C_DEPTH naturally.
  - ram_cnt: 0..C_DEPTH.
  - inflight: 1 bit.
  - ostage: a two-entry register queue with head and skid entries, occ 0..2.
- **Write side.**
  - RAM_WR_EN = WR_VALID & WR_READY.
  - RAM_WR_ADDR = wptr; RAM_WR_DATA = WR_DATA.
  - wptr increments on each write.
  - WR_READY is registered and equals (next ram_cnt < C_DEPTH).
- **Read issue.**
  - pop = RD_VALID & RD_READY.
  - RAM_RD_EN = (ram_cnt != 0) & (occ + inflight - pop < 2).
  - RAM_RD_ADDR = rptr; rptr increments on each issue.
  - inflight is set on the next edge iff RAM_RD_EN.
- **Capture.**
  - When inflight = 1, RAM_RD_DATA is pushed into ostage on that edge.
  - It goes into the head if the head is empty or being popped; otherwise it goes into the skid.
  - On pop with skid occupied, skid moves to head.
- **ram_cnt.** Next value = ram_cnt + RAM_WR_EN - RAM_RD_EN.
  - ram_cnt is computed from registered values, so a word written in cycle N is readable no earlier than N+1. The RAM is never read and written at the same address in the same cycle.
- **Outputs.**
  - RD_VALID = (occ != 0); RD_DATA = head.
  - COUNT = ram_cnt + inflight + occ, registered.
- **Invariants.**
  - occ + inflight ≤ 2.
  - COUNT ≤ C_DEPTH + 2.
  - No write when ram_cnt = C_DEPTH.
  - No read when ram_cnt = 0.

## Timing
- **Reset (RST_N low, asynchronous).**
  - Pointers, ram_cnt, inflight and occ are 0.
  - WR_READY = 0, RD_VALID = 0, COUNT = 0, RAM_WR_EN = 0, RAM_RD_EN = 0.
  - RD_DATA is undefined.
  - WR_READY rises on the first CLK edge after RST_N deasserts.
- **First-word latency.** Write accepted in cycle 0:
  - RAM_RD_EN in cycle 1;
  - RAM_RD_DATA valid in cycle 2;
  - RD_VALID = 1 from cycle 3.
- **Throughput.** Steady streaming with both sides always ready is one word per cycle with no bubbles after the initial fill.
- **Backpressure.**
  - RD_READY low holds RD_DATA stable and RD_VALID high.
  - A word in flight lands in the skid; no data is lost.
- **Full.**
  - WR_READY deasserts the cycle after the write that makes ram_cnt = C_DEPTH.
  - It reasserts the cycle after the first RAM read issue frees a slot.
- **Empty.** RD_VALID drops the cycle after the pop of the last word if nothing is in flight.
- **Simultaneous write and read issue at ram_cnt = C_DEPTH.** Not possible, because WR_READY is already 0; ram_cnt stays consistent.
- **Reset mid-operation.** All contents are discarded immediately and outputs take their reset values. The RAM array is not cleared, and stale data is never presented.

## Test plan
- **Reset values.** Assert RST_N low during traffic → in the same cycle: RD_VALID=0, WR_READY=0, COUNT=0, RAM_WR_EN=RAM_RD_EN=0. After release: WR_READY=1 one edge later.
- **Single word.** Write 0xA5A5_0001 in cycle 0 with RD_READY=1 → RAM_RD_EN in cycle 1, RD_VALID and RD_DATA=0xA5A5_0001 in cycle 3, COUNT back to 0 in cycle 4.
- **Fill to full (C_DEPTH=8).** RD_READY=0, WR_VALID=1 continuously with data 0..11 → exactly 10 words accepted, WR_READY=0 afterwards, COUNT=10, RD_DATA=0.
- **Drain from full.** From the full state, RD_READY=1 → RD_DATA is 0..9 in order with no bubbles, WR_READY reasserts, RD_VALID=0 after word 9.
- **Wrap and stream.** C_DEPTH=8, random WR_VALID/RD_READY over 1000 words of incrementing data → output sequence is identical to input, and pointers wrap ≥ 100 times. Scoreboard checks the invariants every cycle.
- **Skid stress.** Toggle RD_READY every cycle while streaming → no lost or duplicated words, RD_DATA stable whenever RD_VALID & !RD_READY.
